// File: rtl/mem_ctrl_if.sv
// Bundle of the requester, RAM/IO bus and ready signals around mem_ctrl.
// The controller connects through 'slave'; requesters, RAM and the bench
// connect through 'master'.
interface mem_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic              rdy;
   logic              mac_req;
   logic              mac_wr;
   logic [ADDR_W-1:0] mac_a;
   logic [31:0]       mac_dout;
   logic [3:0]        mac_kind;
   logic              mac_busy;
   logic              mac_done;
   logic [31:0]       mac_din;
   logic              if_req;
   logic [ADDR_W-1:0] if_a;
   logic              if_clr;
   logic              if_done;
   logic [31:0]       if_din;
   logic [7:0]        ram_din;
   logic [7:0]        ram_dout;
   logic [ADDR_W-1:0] ram_a;
   logic              ram_wr;
   logic              io_buffer_full;

   modport slave (
      input  rdy, mac_req, mac_wr, mac_a, mac_dout, mac_kind,
      input  if_req, if_a, if_clr, ram_din, io_buffer_full,
      output mac_busy, mac_done, mac_din, if_done, if_din,
      output ram_dout, ram_a, ram_wr
   );

   modport master (
      output rdy, mac_req, mac_wr, mac_a, mac_dout, mac_kind,
      output if_req, if_a, if_clr, ram_din, io_buffer_full,
      input  mac_busy, mac_done, mac_din, if_done, if_din,
      input  ram_dout, ram_a, ram_wr
   );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serialising memory controller. Arbitrates the data port (priority)
// and the instruction-fetch port onto a byte-wide synchronous RAM/IO bus
// and assembles little-endian words for reads.
module mem_ctrl #(
   parameter int         ADDR_W = 32,
   parameter logic [1:0] IO_SEL = 2'b11
) (
   input  logic       clk,
   input  logic       rst,
   mem_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   typedef enum logic {
      OWN_DATA  = 1'b0,
      OWN_FETCH = 1'b1
   } owner_t;

   // Byte count for a one-hot access kind; anything unexpected is a word.
   function automatic logic [2:0] kind_to_n(input logic [3:0] kind);
      logic [2:0] n;
      case (kind)
         4'b0001: n = 3'd1;
         4'b0010: n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

   state_t            state_r, state_s;
   owner_t            owner_r, owner_s;
   logic [2:0]        i_r, i_s;
   logic [2:0]        n_r, n_s;
   logic [ADDR_W-1:0] addr_r, addr_s;
   logic [31:0]       wdata_r, wdata_s;
   logic [31:0]       data_r, data_s;

   logic              fetch_abort_s;
   logic              io_hold_s;
   logic [1:0]        cap_idx_s;
   logic [2:0]        rd_off_s;

   // Fetch abort applies to any busy state owned by the fetch port.
   assign fetch_abort_s = (owner_r == OWN_FETCH) && bus.if_clr && (state_r != ST_IDLE);
   // Writes into the I/O region stall while the I/O write buffer is full.
   assign io_hold_s     = (addr_r[17:16] == IO_SEL) && bus.io_buffer_full;
   // Byte slot filled this cycle: the byte addressed one cycle earlier.
   assign cap_idx_s     = i_r[1:0] - 2'd1;

   // State, counter and latched request registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         owner_r <= OWN_DATA;
         i_r     <= 3'd0;
         n_r     <= 3'd0;
         addr_r  <= '0;
         wdata_r <= 32'h0000_0000;
         data_r  <= 32'h0000_0000;
      end else begin
         state_r <= state_s;
         owner_r <= owner_s;
         i_r     <= i_s;
         n_r     <= n_s;
         addr_r  <= addr_s;
         wdata_r <= wdata_s;
         data_r  <= data_s;
      end
   end

   // Next-state logic: arbitration, byte sequencing, read capture, aborts.
   always_comb begin
      state_s = state_r;
      owner_s = owner_r;
      i_s     = i_r;
      n_s     = n_r;
      addr_s  = addr_r;
      wdata_s = wdata_r;
      data_s  = data_r;
      if (!bus.rdy) begin
         state_s = state_r;
      end else if (fetch_abort_s) begin
         state_s = ST_IDLE;
         i_s     = 3'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.mac_req) begin
                  addr_s  = bus.mac_a;
                  wdata_s = bus.mac_dout;
                  n_s     = kind_to_n(bus.mac_kind);
                  owner_s = OWN_DATA;
                  i_s     = 3'd0;
                  data_s  = 32'h0000_0000;
                  state_s = bus.mac_wr ? ST_WR : ST_RD;
               end else if (bus.if_req && !bus.if_clr) begin
                  addr_s  = bus.if_a;
                  n_s     = 3'd4;
                  owner_s = OWN_FETCH;
                  i_s     = 3'd0;
                  data_s  = 32'h0000_0000;
                  state_s = ST_RD;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_RD: begin
               if (i_r != 3'd0) begin
                  data_s[{cap_idx_s, 3'b000} +: 8] = bus.ram_din;
               end else begin
                  data_s = data_r;
               end
               if (i_r == n_r) begin
                  state_s = ST_DONE;
                  i_s     = 3'd0;
               end else begin
                  i_s     = i_r + 3'd1;
               end
            end
            ST_WR: begin
               if (io_hold_s) begin
                  i_s = i_r;
               end else if (i_r == (n_r - 3'd1)) begin
                  state_s = ST_DONE;
                  i_s     = 3'd0;
               end else begin
                  i_s     = i_r + 3'd1;
               end
            end
            ST_DONE: begin
               state_s = ST_IDLE;
               i_s     = 3'd0;
            end
            default: begin
               state_s = ST_IDLE;
               i_s     = 3'd0;
            end
         endcase
      end
   end

   // While frozen mid-read, keep addressing the byte still awaiting capture
   // so the synchronous RAM presents it again when rdy returns.
   always_comb begin
      if ((state_r == ST_RD) && !bus.rdy && (i_r != 3'd0)) begin
         rd_off_s = i_r - 3'd1;
      end else begin
         rd_off_s = i_r;
      end
   end

   // Bus and handshake outputs decoded from the registered state.
   always_comb begin
      bus.ram_a    = '0;
      bus.ram_dout = 8'h00;
      bus.ram_wr   = 1'b0;
      case (state_r)
         ST_RD: begin
            bus.ram_a = addr_r + ADDR_W'(rd_off_s);
         end
         ST_WR: begin
            bus.ram_a    = addr_r + ADDR_W'(i_r);
            bus.ram_dout = wdata_r[{i_r[1:0], 3'b000} +: 8];
            bus.ram_wr   = bus.rdy && !io_hold_s;
         end
         default: begin
            bus.ram_a = '0;
         end
      endcase
      bus.mac_busy = (state_r == ST_RD) || (state_r == ST_WR) ||
                     ((state_r == ST_DONE) && (owner_r == OWN_FETCH));
      bus.mac_done = bus.rdy && (state_r == ST_DONE) && (owner_r == OWN_DATA);
      bus.if_done  = bus.rdy && (state_r == ST_DONE) && (owner_r == OWN_FETCH) && !bus.if_clr;
      bus.mac_din  = data_r;
      bus.if_din   = data_r;
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl with a synchronous byte RAM model.
module tb_mem_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_mac_done = 0;
   int   n_if_done = 0;

   typedef struct {
      logic        chk;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [7:0]  d;
      int          cyc;
   } wr_t;

   exp_t mac_q[$];
   exp_t if_q[$];
   wr_t  wr_log[$];
   logic [7:0] mem [0:4095];

   mem_ctrl_if #(.ADDR_W(32)) bus ();

   mem_ctrl #(.ADDR_W(32), .IO_SEL(2'b11)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Cycle counter, bumped on every rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [11:0] midx(input logic [31:0] a);
      return {a[17:16], a[9:0]};
   endfunction

   // Synchronous RAM model with one-cycle read latency and a write log.
   always @(posedge clk) begin
      bus.ram_din <= mem[midx(bus.ram_a)];
      if (bus.ram_wr) begin
         mem[midx(bus.ram_a)] <= bus.ram_dout;
         wr_log.push_back('{a: bus.ram_a, d: bus.ram_dout, cyc: cyc});
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Done monitor: pops the scoreboard on every completion pulse.
   always @(negedge clk) begin
      exp_t e;
      if (bus.mac_done) begin
         n_mac_done++;
         if (mac_q.size() == 0) begin
            check("mac_spurious_done", 32'd1, 32'd0);
         end else begin
            e = mac_q.pop_front();
            if (e.chk) check("mac_din", bus.mac_din, e.data);
            check("mac_done_cycle", cyc, e.cyc);
         end
      end
      if (bus.if_done) begin
         n_if_done++;
         if (if_q.size() == 0) begin
            check("if_spurious_done", 32'd1, 32'd0);
         end else begin
            e = if_q.pop_front();
            check("if_din", bus.if_din, e.data);
            check("if_done_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_data(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] kind, input logic chk,
                             input logic [31:0] exp, input int lat);
      bus.mac_req  = 1'b1;
      bus.mac_wr   = wr;
      bus.mac_a    = a;
      bus.mac_dout = d;
      bus.mac_kind = kind;
      mac_q.push_back('{chk: chk, data: exp, cyc: cyc + lat});
   endtask

   task automatic wait_mac(input string tag);
      int start;
      int n;
      start = n_mac_done;
      n = 0;
      while (n_mac_done == start && n < 40) begin
         tick();
         n++;
      end
      if (n_mac_done == start) check({tag, "_timeout"}, 32'd0, 32'd1);
      bus.mac_req = 1'b0;
   endtask

   task automatic wait_if(input string tag);
      int start;
      int n;
      start = n_if_done;
      n = 0;
      while (n_if_done == start && n < 40) begin
         tick();
         n++;
      end
      if (n_if_done == start) check({tag, "_timeout"}, 32'd0, 32'd1);
      bus.if_req = 1'b0;
   endtask

   initial begin
      int t;
      for (int k = 0; k < 4096; k++) mem[k] = 8'h00;
      mem[midx(32'h100)] = 8'h11;
      mem[midx(32'h101)] = 8'h22;
      mem[midx(32'h102)] = 8'h33;
      mem[midx(32'h103)] = 8'h44;
      mem[midx(32'h010)] = 8'hA5;
      mem[midx(32'h011)] = 8'h5A;
      mem[midx(32'h000)] = 8'h01;
      mem[midx(32'h001)] = 8'h02;
      mem[midx(32'h002)] = 8'h03;
      mem[midx(32'h003)] = 8'h04;

      bus.rdy = 1'b1;
      bus.mac_req = 1'b0;
      bus.mac_wr = 1'b0;
      bus.mac_a = 32'h0;
      bus.mac_dout = 32'h0;
      bus.mac_kind = 4'b0000;
      bus.if_req = 1'b0;
      bus.if_a = 32'h0;
      bus.if_clr = 1'b0;
      bus.io_buffer_full = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
      check("rst_ram_a", bus.ram_a, 32'd0);
      check("rst_mac_busy", {31'd0, bus.mac_busy}, 32'd0);
      check("rst_mac_din", bus.mac_din, 32'd0);
      rst = 1'b0;
      tick();

      // lw from 0x100
      t = cyc;
      issue_data(1'b0, 32'h100, 32'h0, 4'b0100, 1'b1, 32'h4433_2211, 6);
      check("lw_idle_busy", {31'd0, bus.mac_busy}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("lw_ram_a", bus.ram_a, 32'h100 + k);
         check("lw_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
         check("lw_busy", {31'd0, bus.mac_busy}, 32'd1);
      end
      tick();
      check("lw_busy_last", {31'd0, bus.mac_busy}, 32'd1);
      wait_mac("lw");

      // lw with rdy dropped for two cycles mid-read
      tick();
      issue_data(1'b0, 32'h100, 32'h0, 4'b0100, 1'b1, 32'h4433_2211, 8);
      tick();
      tick();
      bus.rdy = 1'b0;
      tick();
      tick();
      bus.rdy = 1'b1;
      wait_mac("lw_rdy");

      // sb of 0xDEADBEEF to 0x200
      tick();
      wr_log.delete();
      issue_data(1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0001, 1'b0, 32'h0, 2);
      tick();
      check("sb_ram_wr", {31'd0, bus.ram_wr}, 32'd1);
      check("sb_ram_dout", {24'd0, bus.ram_dout}, 32'hEF);
      wait_mac("sb");
      repeat (3) tick();
      check("sb_write_count", wr_log.size(), 32'd1);
      if (wr_log.size() > 0) begin
         check("sb_write_addr", wr_log[0].a, 32'h200);
         check("sb_write_data", {24'd0, wr_log[0].d}, 32'hEF);
      end

      // lh and fetch requested together: data first, then fetch
      issue_data(1'b0, 32'h10, 32'h0, 4'b0010, 1'b1, 32'h0000_5AA5, 4);
      bus.if_req = 1'b1;
      bus.if_a = 32'h0;
      if_q.push_back('{chk: 1'b1, data: 32'h0403_0201, cyc: cyc + 11});
      wait_mac("lh_prio");
      wait_if("fetch_after");

      // sw into the I/O region with the buffer full for 3 cycles at k = 1
      tick();
      wr_log.delete();
      t = cyc;
      issue_data(1'b1, 32'h30004, 32'hCAFE_F00D, 4'b0100, 1'b0, 32'h0, 8);
      tick();
      tick();
      bus.io_buffer_full = 1'b1;
      tick();
      tick();
      tick();
      bus.io_buffer_full = 1'b0;
      wait_mac("sw_io");
      check("sw_write_count", wr_log.size(), 32'd4);
      if (wr_log.size() == 4) begin
         logic [31:0] sw_data;
         sw_data = 32'hCAFE_F00D;
         for (int k = 0; k < 4; k++) begin
            check("sw_write_addr", wr_log[k].a, 32'h30004 + k);
            check("sw_write_data", {24'd0, wr_log[k].d}, {24'd0, sw_data[8*k +: 8]});
         end
         check("sw_byte1_cycle", wr_log[1].cyc, t + 5);
      end

      // Fetch aborted by if_clr at k = 2, then an immediate lb
      tick();
      issue_fetch_abort();

      // Reset during an lw at k = 2
      tick();
      issue_data(1'b0, 32'h100, 32'h0, 4'b0100, 1'b1, 32'h4433_2211, 6);
      repeat (3) tick();
      rst = 1'b1;
      #1;
      check("arst_ram_a", bus.ram_a, 32'd0);
      check("arst_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
      check("arst_mac_busy", {31'd0, bus.mac_busy}, 32'd0);
      check("arst_mac_done", {31'd0, bus.mac_done}, 32'd0);
      check("arst_mac_din", bus.mac_din, 32'd0);
      bus.mac_req = 1'b0;
      mac_q.delete();
      repeat (2) tick();
      rst = 1'b0;
      repeat (8) tick();
      issue_data(1'b0, 32'h101, 32'h0, 4'b0001, 1'b1, 32'h0000_0022, 3);
      wait_mac("lb_after_rst");

      repeat (3) tick();
      check("mac_q_drained", mac_q.size(), 32'd0);
      check("if_q_drained", if_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   task automatic issue_fetch_abort();
      bus.if_req = 1'b1;
      bus.if_a = 32'h0;
      repeat (3) tick();
      check("clr_busy_in_rd", {31'd0, bus.mac_busy}, 32'd1);
      bus.if_clr = 1'b1;
      bus.if_req = 1'b0;
      tick();
      bus.if_clr = 1'b0;
      check("clr_idle_busy", {31'd0, bus.mac_busy}, 32'd0);
      issue_data(1'b0, 32'h100, 32'h0, 4'b0001, 1'b1, 32'h0000_0011, 3);
      wait_mac("lb_after_clr");
   endtask

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
